// File: rtl/dec_5_to_32_seq.sv
// dec_5_to_32_seq: sequenced one-hot register-select decoder.
// Starting at base_idx, it drives one one-hot select per clock for len+1 consecutive registers.
// The index wraps modulo 2**IDX_W.
// Ports:
//   clock     rising-edge clock
//   clear     asynchronous active-low reset
//   start     sweep request (accepted in IDLE or in the final beat)
//   base_idx  first register index of the sweep
//   len       beats minus one
//   hold      freezes an active sweep
//   dir       (only with DEC_REVERSE_EN) 1 = descending sweep
//   busy      high for every beat of a sweep
//   dec_valid high when dec_out carries a select
//   dec_out   one-hot select, zero when not valid
//   dec_idx   index currently driven
//   done      high during the final beat
// Macro DEC_REVERSE_EN adds the dir input for descending sweeps.
module dec_5_to_32_seq #(
  parameter int IDX_W = 5,
  parameter int OUT_W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [IDX_W-1:0] base_idx,
  input  logic [IDX_W-1:0] len,
  input  logic             hold,
`ifdef DEC_REVERSE_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             dec_valid,
  output logic [OUT_W-1:0] dec_out,
  output logic [IDX_W-1:0] dec_idx,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, rem_q, rem_d;
  logic             dir_q, dir_d, dir_in;
  logic [OUT_W-1:0] out_q, out_d;
  logic             done_q, done_d;
`ifdef DEC_REVERSE_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
  // A new request is accepted from IDLE or at an unstalled final beat; hold is ignored in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    if (state_q == IDLE || (!hold && rem_q == '0)) begin
      state_d = start ? RUN : IDLE;
      idx_d   = start ? base_idx : '0;
      rem_d   = start ? len : '0;
      dir_d   = start ? dir_in : 1'b0;
    end else if (!hold) begin
      idx_d = dir_q ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
      rem_d = rem_q - IDX_W'(1);
    end
  end
  // The decoded select and done flag are precomputed from next state so every output comes straight from a flop.
  always_comb begin
    out_d  = (state_d == RUN) ? OUT_W'(1) << idx_d : '0;
    done_d = (state_d == RUN) && (rem_d == '0);
  end
  assign busy      = (state_q == RUN);
  assign dec_valid = (state_q == RUN);
  assign dec_out   = out_q;
  assign dec_idx   = idx_q;
  assign done      = done_q;
endmodule

// File: tb/tb_dec_5_to_32_seq.sv
// tb_dec_5_to_32_seq: randomized and directed check of dec_5_to_32_seq against a beat-queue model.
module tb_dec_5_to_32_seq;
  logic        clock = 1'b0, clear = 1'b0, start = 1'b0, hold = 1'b0, dir = 1'b0;
  logic [4:0]  base_idx = '0, len = '0;
  logic        busy, dec_valid, done;
  logic [31:0] dec_out;
  logic [4:0]  dec_idx;
  int n_cmp = 0, n_err = 0;
  int q[$];

  dec_5_to_32_seq dut (
    .clock(clock), .clear(clear), .start(start), .base_idx(base_idx), .len(len), .hold(hold),
`ifdef DEC_REVERSE_EN
    .dir(dir),
`endif
    .busy(busy), .dec_valid(dec_valid), .dec_out(dec_out), .dec_idx(dec_idx), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill();
    int step;
    step = 1;
`ifdef DEC_REVERSE_EN
    if (dir) step = -1;
`endif
    for (int i = 0; i <= int'(len); i++) q.push_back((int'(base_idx) + 1024 + step * i) % 32);
  endtask

  task automatic model_edge();
    if (q.size() == 0) begin
      if (start) fill();
    end else if (!hold) begin
      if (q.size() == 1) begin
        void'(q.pop_front());
        if (start) fill();
      end else void'(q.pop_front());
    end
  endtask

  task automatic check_all();
    logic act;
    act = (q.size() != 0);
    chk("busy", 32'(busy), 32'(act));
    chk("valid", 32'(dec_valid), 32'(act));
    chk("dec_idx", 32'(dec_idx), act ? q[0] : 0);
    chk("dec_out", dec_out, act ? (32'h1 << q[0]) : 32'h0);
    chk("done", 32'(done), 32'(q.size() == 1));
  endtask

  task automatic cyc(input logic s, input int b, input int l, input logic h, input logic d);
    start = s; base_idx = 5'(b); len = 5'(l); hold = h; dir = d;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic pulse_reset();
    #2 clear = 1'b0;
    #1 q.delete();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out", dec_out, 0);
    chk("rst_idx", 32'(dec_idx), 0);
    chk("rst_done", 32'(done), 0);
    #1 clear = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_all();
    clear = 1'b1;
    cyc(1, 5, 0, 0, 0);
    chk("single_out", dec_out, 32'h20);
    chk("single_done", 32'(done), 1);
    cyc(0, 0, 0, 0, 0);
    chk("single_after", dec_out, 32'h0);
    cyc(1, 30, 3, 0, 0);
    chk("wrap0", dec_out, 32'h40000000);
    cyc(0, 0, 0, 0, 0);
    chk("wrap1", dec_out, 32'h80000000);
    cyc(0, 0, 0, 0, 0);
    chk("wrap2", dec_out, 32'h1);
    chk("wrap2_nodone", 32'(done), 0);
    cyc(0, 0, 0, 0, 0);
    chk("wrap3", dec_out, 32'h2);
    chk("wrap3_done", 32'(done), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("hold_a", dec_out, 32'h2);
    cyc(0, 0, 0, 1, 0);
    chk("hold_b", dec_out, 32'h2);
    cyc(0, 0, 0, 1, 0);
    chk("hold_c", dec_out, 32'h2);
    cyc(0, 0, 0, 0, 0);
    chk("hold_end", dec_out, 32'h4);
    chk("hold_done", 32'(done), 1);
    cyc(0, 0, 0, 1, 0);
    chk("hold_done_frozen", 32'(done), 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 4, 1, 0, 0);
    cyc(1, 9, 3, 0, 0);
    chk("b2b_ignore", dec_out, 32'h20);
    cyc(1, 16, 0, 0, 0);
    chk("b2b_out", dec_out, 32'h10000);
    chk("b2b_busy", 32'(busy), 1);
    cyc(0, 0, 0, 0, 0);
`ifdef DEC_REVERSE_EN
    cyc(1, 1, 2, 0, 1);
    chk("rev0", dec_out, 32'h2);
    cyc(0, 0, 0, 0, 0);
    chk("rev1", dec_out, 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("rev2", dec_out, 32'h80000000);
    chk("rev2_done", 32'(done), 1);
    cyc(0, 0, 0, 0, 0);
`endif
    cyc(1, 3, 10, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    chk("pre_rst_idx", 32'(dec_idx), 7);
    pulse_reset();
    @(negedge clock);
    check_all();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      cyc(($urandom_range(0, 2) == 0), int'($urandom_range(0, 31)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
